fetch_stage: RTL and testbench

//  - Instruction-fetch stage plus IF/ID pipeline register of the MIPS datapath; sits directly upstream of the UC decoder.
//  - Owns the PC, drives the instruction-memory address, latches {PC+4, instruction} into IF/ID, and presents if_id_op = instr[31:26] to UC.OP.
//  - Supports stall from the hazard unit, redirect on a taken BEQ, and a HALT opcode that freezes fetch.

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_if_id_reg.sv | 39 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, special instruction words
// and the opcode map shared with the UC decoder.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetchState_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [5:0]  HALT_OP   = 6'b111111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
      return instr[31:26];
   endfunction

   function automatic logic [31:0] alignWord(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: squash loads a bubble, hold keeps the current entry,
// otherwise the fetched {pc+4, instruction} is captured as a valid entry.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        squash,
   input  logic [31:0] nextPc4,
   input  logic [31:0] nextInstr,
   output logic [31:0] pc4,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic        valid
);
   import fetch_stage_pkg::*;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc4   <= 32'h0000_0000;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (squash) begin
         pc4   <= 32'h0000_0000;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!hold) begin
         pc4   <= nextPc4;
         instr <= nextInstr;
         valid <= 1'b1;
      end
   end

   assign op = opcodeOf(instr);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, BOOT/RUN/HALT control and the IF/ID register.
// Optional saturating stall counter built only when IF_PERF_CNT_EN is defined.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP   = fetch_stage_pkg::HALT_OP,
   parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic [5:0]  if_id_op,
   output logic        if_id_valid,
   output logic        halted
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);
   import fetch_stage_pkg::*;

   fetchState_t state;
   fetchState_t stateNext;
   logic [31:0] pc;
   logic [31:0] pcNext;
   logic [31:0] pcPlus4;
   logic        ifIdHold;
   logic        ifIdSquash;

   assign pcPlus4 = pc + 32'd4;   // modulo 2^32: 0xFFFF_FFFC wraps to 0

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      stateNext  = state;
      pcNext     = pc;
      ifIdHold   = 1'b0;
      ifIdSquash = 1'b0;
      unique case (state)
         BOOT: begin
            ifIdSquash = 1'b1;
            stateNext  = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               pcNext     = alignWord(branch_target);
               ifIdSquash = 1'b1;
            end else if (stall) begin
               ifIdHold = 1'b1;
            end else begin
               pcNext = pcPlus4;
               if (opcodeOf(imem_rdata) == HALT_OP)
                  stateNext = HALT;
            end
         end
         HALT: begin
            ifIdSquash = 1'b1;
         end
         default: begin
            stateNext  = BOOT;
            ifIdSquash = 1'b1;
         end
      endcase
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .hold      (ifIdHold),
      .squash    (ifIdSquash),
      .nextPc4   (pcPlus4),
      .nextInstr (imem_rdata),
      .pc4       (if_id_pc4),
      .instr     (if_id_instr),
      .op        (if_id_op),
      .valid     (if_id_valid)
   );

   assign imem_addr = pc;
   assign halted    = (state == HALT);

`ifdef IF_PERF_CNT_EN
   logic stallEvent;

   // A branch in the same cycle overrides the stall, so it is not counted.
   assign stallEvent = (state == RUN) && stall && !branch_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= 16'h0000;
      else if (stallEvent && stall_cnt != STALL_CNT_MAX)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural fetch model compared every cycle,
// plus directed literal checks for boot, stall, branch, wrap, halt and async reset.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic [5:0]  if_id_op;
   logic        if_id_valid;
   logic        halted;
`ifdef IF_PERF_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic cmpEn = 1'b0;

   // Instruction memory contents; one address can be turned into a HALT word.
   logic        haltEn = 1'b0;
   logic [31:0] haltAddr = 32'h0;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_id_pc4     (if_id_pc4),
      .if_id_instr   (if_id_instr),
      .if_id_op      (if_id_op),
      .if_id_valid   (if_id_valid),
      .halted        (halted)
`ifdef IF_PERF_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      logic [5:0] op;
      case (a[4:2])
         3'd0:    op = OP_RTYPE;
         3'd1:    op = OP_ADDI;
         3'd2:    op = OP_SLTI;
         3'd3:    op = OP_ANDI;
         3'd4:    op = OP_ORI;
         3'd5:    op = OP_BEQ;
         3'd6:    op = OP_LW;
         default: op = OP_SW;
      endcase
      return {op, a[27:2]};
   endfunction

   function automatic logic [31:0] imemModel(input logic [31:0] a);
      if (haltEn && a == haltAddr)
         return {HALT_OP, 26'd0};
      return memWord(a);
   endfunction

   assign imem_rdata = imemModel(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the stage must present after each edge.
   logic [31:0] mPc = 32'h0;
   logic [31:0] mPc4 = 32'h0;
   logic [31:0] mInstr = 32'h0;
   logic        mValid = 1'b0;
   logic        mBoot = 1'b1;
   logic        mHalted = 1'b0;
   int          mCnt = 0;

   always @(posedge clk or posedge rst) begin
      logic [31:0] w;
      if (rst) begin
         mPc = 32'h0; mPc4 = 32'h0; mInstr = 32'h0; mValid = 1'b0;
         mBoot = 1'b1; mHalted = 1'b0; mCnt = 0;
      end else if (mBoot || mHalted) begin
         mPc4 = 32'h0; mInstr = 32'h0; mValid = 1'b0;
         mBoot = 1'b0;
      end else if (branch_taken) begin
         mPc = {branch_target[31:2], 2'b00};
         mPc4 = 32'h0; mInstr = 32'h0; mValid = 1'b0;
      end else if (stall) begin
         if (mCnt < 65535) mCnt++;
      end else begin
         w = imemModel(mPc);
         mPc4 = mPc + 32'd4;
         mInstr = w;
         mValid = 1'b1;
         mHalted = (w[31:26] == 6'b111111);
         mPc = mPc + 32'd4;
      end
   end

   always @(negedge clk) begin
      if (cmpEn) begin
         check("model_imem_addr", imem_addr, mPc);
         check("model_if_id_pc4", if_id_pc4, mPc4);
         check("model_if_id_instr", if_id_instr, mInstr);
         check("model_if_id_op", 32'(if_id_op), 32'(mInstr[31:26]));
         check("model_if_id_valid", 32'(if_id_valid), 32'(mValid));
         check("model_halted", 32'(halted), 32'(mHalted));
`ifdef IF_PERF_CNT_EN
         check("model_stall_cnt", 32'(stall_cnt), 32'(mCnt));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1 rst = 1'b1;
      cmpEn = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(if_id_valid), 32'h0);

      step();
      check("boot_valid", 32'(if_id_valid), 32'h0);
      check("boot_pc_hold", imem_addr, 32'h0);

      step();
      check("first_pc4", if_id_pc4, 32'h4);
      check("first_instr", if_id_instr, memWord(32'h0));
      check("first_valid", 32'(if_id_valid), 32'h1);
      check("first_pc", imem_addr, 32'h4);

      step();
      check("second_pc", imem_addr, 32'h8);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", imem_addr, 32'h8);
         check("stall_instr", if_id_instr, memWord(32'h4));
         check("stall_pc4", if_id_pc4, 32'h8);
      end
`ifdef IF_PERF_CNT_EN
      check("stall_cnt_3", 32'(stall_cnt), 32'd3);
`endif

      branch_taken = 1'b1;
      branch_target = 32'h0000_0043;
      step();
      check("branch_pc", imem_addr, 32'h40);
      check("branch_bubble_valid", 32'(if_id_valid), 32'h0);
      check("branch_bubble_op", 32'(if_id_op), 32'h0);
      stall = 1'b0;

      branch_target = 32'hFFFF_FFFF;
      step();
      check("wrap_branch_pc", imem_addr, 32'hFFFF_FFFC);
      branch_taken = 1'b0;
      step();
      check("wrap_pc", imem_addr, 32'h0);
      check("wrap_pc4", if_id_pc4, 32'h0);
      check("wrap_instr", if_id_instr, memWord(32'hFFFF_FFFC));

      for (int i = 0; i < 400; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         branch_target = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFE : $urandom;
         step();
      end

      stall = 1'b0;
      branch_taken = 1'b1;
      branch_target = 32'h0000_0100;
      haltEn = 1'b1;
      haltAddr = 32'h0000_0108;
      step();
      branch_taken = 1'b0;
      repeat (3) step();
      check("halt_instr", if_id_instr, 32'hFC00_0000);
      check("halt_op", 32'(if_id_op), 32'h3F);
      check("halt_valid", 32'(if_id_valid), 32'h1);
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_pc", imem_addr, 32'h10C);
      for (int i = 0; i < 6; i++) begin
         branch_taken = i[0];
         stall = i[1];
         branch_target = 32'h0000_0200;
         step();
         check("halted_valid", 32'(if_id_valid), 32'h0);
         check("halted_pc", imem_addr, 32'h10C);
         check("halted_flag", 32'(halted), 32'h1);
      end

      branch_taken = 1'b0;
      stall = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_rst_pc", imem_addr, 32'h0);
      check("async_rst_pc4", if_id_pc4, 32'h0);
      check("async_rst_instr", if_id_instr, 32'h0);
      check("async_rst_valid", 32'(if_id_valid), 32'h0);
      check("async_rst_halted", 32'(halted), 32'h0);
`ifdef IF_PERF_CNT_EN
      check("async_rst_cnt", 32'(stall_cnt), 32'h0);
`endif
      @(posedge clk);
      #2 rst = 1'b0;
      haltEn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         step();
      end

      cmpEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
